timer_irq_source: RTL and testbench
===================================

// Module: timer_irq_source
// PURPOSE
//  Memory-mapped interval timer that generates the IRQ level consumed by the CPU controller/PC logic.
//  Sits on the data-memory bus beside data RAM; decoded by address, accessed with lw/sw.
//  Counts up from a reload value and raises IRQ on overflow.
//  IRQ holds until software clears the status bit from the handler.
// PARAMETERS
//  BASE_ADDR  32'h4000_0000  byte address of TH; TL=+0x04, TCON=+0x08, SYSTICK=+0x14
//  DIV        1              timer ticks once every DIV enabled clk cycles (DIV>=1)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  MemRead    in   1   bus read strobe (lw)
//  MemWrite   in   1   bus write strobe (sw)
//  Addr       in   32  bus byte address (ALU result)
//  WriteData  in   32  bus write data (rt)
//  ReadData   out  32  read data, combinational
//  IRQ        out  1   interrupt request level to controller
// BEHAVIOUR
//  Registers: TH[31:0] reload; TL[31:0] counter; TCON[2:0] = {irq_status, irq_en, tmr_en}.
//  Reset (async): TH=0, TL=0, TCON=3'b000, prescaler=0, SYSTICK=0 -> IRQ=0, ReadData=0.
//  Decode: exact 32-bit compare against BASE_ADDR+offset; any other address = no hit, no effect.
//  Write: MemWrite & hit -> register updated at next rising clk edge; 1-cycle latency.
//   TH/TL take WriteData[31:0]; TCON takes WriteData[2:0]; upper bits ignored.
//  Read: MemRead & hit -> ReadData = register (TCON zero-extended), same cycle; else 32'h0.
//   MemRead and MemWrite both high: write still occurs; ReadData shows pre-write value.
//  Prescaler: when tmr_en=1, counts 0..DIV-1; tick asserted the cycle it equals DIV-1, then wraps to 0.
//   tmr_en=0 freezes TL and holds prescaler at 0.
//   DIV=1: tick every enabled cycle.
//  Tick: TL==32'hFFFF_FFFF -> TL<=TH and overflow event; else TL<=TL+1 (32-bit, no carry out).
//  Overflow event: irq_status<=1 only if irq_en=1 at that edge; otherwise the event is dropped.
//  IRQ = irq_en & irq_status (registered bits, glitch-free); level held until status cleared.
//  Priority at one edge:
//   TL write beats tick: TL=WriteData, no overflow that cycle.
//   TH write + overflow: reload uses OLD TH.
//   TCON write + overflow event: bits[1:0] from WriteData; irq_status = 1 (set wins, no event lost).
//  Clearing: software writes TCON with bit2=0; IRQ falls the cycle after the edge.
//   Writing bit2=1 sets status (software-raised IRQ, for test).
//  Reset mid-count or with IRQ high: all state cleared immediately, no pending event retained.
// CONFIGURATION
//  TIMER_SYSTICK_EN defined:
//   free-running 32-bit SYSTICK counter, +1 every clk from reset, wraps at 2^32.
//   Readable at BASE_ADDR+0x14; writes ignored.
//  TIMER_SYSTICK_EN undefined:
//   no counter logic; +0x14 is an unmapped address (reads 0, writes ignored).
// TESTING
//  1. Reset, read TH/TL/TCON/+0x0C -> all 0; IRQ=0.
//  2. DIV=1; TH=FFFF_FFFC, TL=FFFF_FFFE, TCON=3 -> TL FFFF_FFFF after 1 clk.
//     Next clk: TL=FFFF_FFFC, TCON reads 7, IRQ=1.
//  3. With IRQ=1, sw TCON=3 -> IRQ=0 next cycle; counting continues uninterrupted.
//  4. TCON=1 (irq_en=0), force overflow -> TL reloads, TCON reads 1, IRQ stays 0.
//  5. Overflow edge coincident with sw TCON=3 -> TCON reads 7, IRQ=1.
//     Overflow edge coincident with sw TL=5 -> TL=5, no IRQ.
//  6. DIV=4, TL=0, TCON=1 for 8 clks -> TL=2; SYSTICK (macro on) = cycles since reset, macro off = 0.

Source files
------------

// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer (TH reload, TL counter, TCON control/status) driving a level IRQ.
// Optional free-running SYSTICK counter at BASE_ADDR+0x14 when TIMER_SYSTICK_EN is defined.
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          DIV       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ
);

  localparam logic [31:0] ADDR_TH  = BASE_ADDR;
  localparam logic [31:0] ADDR_TL  = BASE_ADDR + 32'h04;
  localparam logic [31:0] ADDR_TC  = BASE_ADDR + 32'h08;
  localparam logic [31:0] DIV_LAST = 32'(DIV - 1);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [31:0] r_presc;
  logic        r_tmr_en;
  logic        r_irq_en;
  logic        r_irq_status;

  logic w_hit_th;
  logic w_hit_tl;
  logic w_hit_tc;
  logic w_wr_th;
  logic w_wr_tl;
  logic w_wr_tc;
  logic w_tick;
  logic w_ovf;
  logic w_set_status;

  assign w_hit_th = (Addr == ADDR_TH);
  assign w_hit_tl = (Addr == ADDR_TL);
  assign w_hit_tc = (Addr == ADDR_TC);
  assign w_wr_th  = MemWrite & w_hit_th;
  assign w_wr_tl  = MemWrite & w_hit_tl;
  assign w_wr_tc  = MemWrite & w_hit_tc;

  assign w_tick = r_tmr_en & (r_presc == DIV_LAST);
  // A software TL write overrides the tick, so it also suppresses the overflow.
  assign w_ovf        = w_tick & (r_tl == 32'hFFFF_FFFF) & ~w_wr_tl;
  assign w_set_status = w_ovf & r_irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (!r_tmr_en || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th <= '0;
    end else if (w_wr_th) begin
      r_th <= WriteData;
    end
  end

  // Reload reads r_th before any same-edge TH write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tl <= '0;
    end else if (w_wr_tl) begin
      r_tl <= WriteData;
    end else if (w_tick) begin
      r_tl <= (r_tl == 32'hFFFF_FFFF) ? r_th : r_tl + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmr_en     <= 1'b0;
      r_irq_en     <= 1'b0;
      r_irq_status <= 1'b0;
    end else if (w_wr_tc) begin
      r_tmr_en     <= WriteData[0];
      r_irq_en     <= WriteData[1];
      r_irq_status <= WriteData[2] | w_set_status;
    end else if (w_set_status) begin
      r_irq_status <= 1'b1;
    end
  end

  assign IRQ = r_irq_en & r_irq_status;

`ifdef TIMER_SYSTICK_EN
  localparam logic [31:0] ADDR_ST = BASE_ADDR + 32'h14;
  logic [31:0] r_systick;
  logic        w_hit_st;

  assign w_hit_st = (Addr == ADDR_ST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
    end
  end
`endif

  always_comb begin
    ReadData = 32'h0;
    if (MemRead) begin
      if (w_hit_th) begin
        ReadData = r_th;
      end else if (w_hit_tl) begin
        ReadData = r_tl;
      end else if (w_hit_tc) begin
        ReadData = {29'h0, r_irq_status, r_irq_en, r_tmr_en};
      end
`ifdef TIMER_SYSTICK_EN
      else if (w_hit_st) begin
        ReadData = r_systick;
      end
`endif
    end
  end

endmodule

// File: tb/tb_timer_irq_source.sv
// Scoreboard bench for timer_irq_source: DIV=1 instance for timing/priority, DIV=4 for the prescaler.
module tb_timer_irq_source;

  localparam logic [31:0] A_TH = 32'h4000_0000;
  localparam logic [31:0] A_TL = 32'h4000_0004;
  localparam logic [31:0] A_TC = 32'h4000_0008;
  localparam logic [31:0] A_UN = 32'h4000_000C;
  localparam logic [31:0] A_ST = 32'h4000_0014;

  logic        clk;
  logic        reset;
  logic        mr  [2];
  logic        mw  [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic [31:0] rdd [2];
  logic        irq [2];

  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] e;
  logic [31:0] cyc;
  int          n_chk;
  int          n_err;

  timer_irq_source #(.BASE_ADDR(32'h4000_0000), .DIV(1)) u_dut0 (
    .clk(clk), .reset(reset), .MemRead(mr[0]), .MemWrite(mw[0]), .Addr(ad[0]),
    .WriteData(wd[0]), .ReadData(rdd[0]), .IRQ(irq[0])
  );

  timer_irq_source #(.BASE_ADDR(32'h4000_0000), .DIV(4)) u_dut1 (
    .clk(clk), .reset(reset), .MemRead(mr[1]), .MemWrite(mw[1]), .Addr(ad[1]),
    .WriteData(wd[1]), .ReadData(rdd[1]), .IRQ(irq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count since reset release, for SYSTICK.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    mw[s] = 1'b1; ad[s] = a; wd[s] = v;
    @(posedge clk);
    #1;
    mw[s] = 1'b0; ad[s] = 32'h0; wd[s] = 32'h0;
  endtask

  task automatic rd(input int s, input logic [31:0] a, output logic [31:0] d);
    mr[s] = 1'b1; ad[s] = a;
    #1;
    d = rdd[s];
    mr[s] = 1'b0; ad[s] = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [4];
    addrs[0] = A_TH; addrs[1] = A_TL; addrs[2] = A_TC; addrs[3] = A_UN;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(0, addrs[i], got);
      e = exp_q.pop_front(); n_chk++;
      if (got !== e) begin n_err++; $display("FAIL reset_read[%0d] got=%h exp=%h", i, got, e); end
    end
    n_chk++;
    if (irq[0] !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq[0]); end
  endtask

  task automatic test_overflow_irq();
    wr(0, A_TH, 32'hFFFF_FFFC);
    wr(0, A_TL, 32'hFFFF_FFFE);
    wr(0, A_TC, 32'h3);
    exp_q.push_back(32'hFFFF_FFFE);
    rd(0, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL ovf_tl0 got=%h exp=%h", got, e); end
    step();
    exp_q.push_back(32'hFFFF_FFFF);
    rd(0, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL ovf_tl1 got=%h exp=%h", got, e); end
    step();
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h7);
    rd(0, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL ovf_reload got=%h exp=%h", got, e); end
    rd(0, A_TC, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL ovf_tcon got=%h exp=%h", got, e); end
    n_chk++;
    if (irq[0] !== 1'b1) begin n_err++; $display("FAIL ovf_irq got=%b exp=1", irq[0]); end
  endtask

  task automatic test_clear();
    wr(0, A_TC, 32'h3);
    n_chk++;
    if (irq[0] !== 1'b0) begin n_err++; $display("FAIL clr_irq got=%b exp=0", irq[0]); end
    exp_q.push_back(32'hFFFF_FFFD);
    exp_q.push_back(32'h3);
    rd(0, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL clr_tl got=%h exp=%h", got, e); end
    rd(0, A_TC, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL clr_tcon got=%h exp=%h", got, e); end
    step();
    exp_q.push_back(32'hFFFF_FFFE);
    rd(0, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL clr_tl_next got=%h exp=%h", got, e); end
  endtask

  task automatic test_irq_disabled();
    wr(0, A_TC, 32'h0);
    wr(0, A_TL, 32'hFFFF_FFFF);
    wr(0, A_TC, 32'h1);
    step();
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h1);
    rd(0, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL dis_tl got=%h exp=%h", got, e); end
    rd(0, A_TC, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL dis_tcon got=%h exp=%h", got, e); end
    n_chk++;
    if (irq[0] !== 1'b0) begin n_err++; $display("FAIL dis_irq got=%b exp=0", irq[0]); end
    wr(0, A_TC, 32'h0);
  endtask

  task automatic test_coincident();
    // TCON write on the overflow edge: status still set.
    wr(0, A_TC, 32'h2);
    wr(0, A_TL, 32'hFFFF_FFFF);
    wr(0, A_TC, 32'h3);
    wr(0, A_TC, 32'h3);
    exp_q.push_back(32'h7);
    exp_q.push_back(32'hFFFF_FFFC);
    rd(0, A_TC, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL co_tc_tcon got=%h exp=%h", got, e); end
    rd(0, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL co_tc_tl got=%h exp=%h", got, e); end
    n_chk++;
    if (irq[0] !== 1'b1) begin n_err++; $display("FAIL co_tc_irq got=%b exp=1", irq[0]); end
    // TL write on the overflow edge: write wins, no IRQ.
    wr(0, A_TC, 32'h2);
    wr(0, A_TL, 32'hFFFF_FFFF);
    wr(0, A_TC, 32'h3);
    wr(0, A_TL, 32'h5);
    exp_q.push_back(32'h5);
    exp_q.push_back(32'h3);
    rd(0, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL co_tl_tl got=%h exp=%h", got, e); end
    rd(0, A_TC, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL co_tl_tcon got=%h exp=%h", got, e); end
    n_chk++;
    if (irq[0] !== 1'b0) begin n_err++; $display("FAIL co_tl_irq got=%b exp=0", irq[0]); end
    step();
    exp_q.push_back(32'h6);
    rd(0, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL co_tl_next got=%h exp=%h", got, e); end
    // TH write on the overflow edge: reload uses the old TH.
    wr(0, A_TC, 32'h0);
    wr(0, A_TL, 32'hFFFF_FFFF);
    wr(0, A_TC, 32'h1);
    wr(0, A_TH, 32'h0000_0100);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0100);
    rd(0, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL co_th_tl got=%h exp=%h", got, e); end
    rd(0, A_TH, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL co_th_th got=%h exp=%h", got, e); end
    wr(0, A_TC, 32'h0);
  endtask

  task automatic test_sw_raise();
    wr(0, A_TC, 32'h6);
    exp_q.push_back(32'h6);
    rd(0, A_TC, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL sw_tcon got=%h exp=%h", got, e); end
    n_chk++;
    if (irq[0] !== 1'b1) begin n_err++; $display("FAIL sw_irq got=%b exp=1", irq[0]); end
    wr(0, A_TC, 32'h0);
    n_chk++;
    if (irq[0] !== 1'b0) begin n_err++; $display("FAIL sw_clr_irq got=%b exp=0", irq[0]); end
  endtask

  task automatic test_both_strobe();
    wr(0, A_TH, 32'hAAAA_0000);
    exp_q.push_back(32'hAAAA_0000);
    exp_q.push_back(32'h1234_5678);
    @(negedge clk);
    mr[0] = 1'b1; mw[0] = 1'b1; ad[0] = A_TH; wd[0] = 32'h1234_5678;
    #1;
    got = rdd[0];
    e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL both_pre got=%h exp=%h", got, e); end
    @(posedge clk);
    #1;
    mr[0] = 1'b0; mw[0] = 1'b0; ad[0] = 32'h0; wd[0] = 32'h0;
    rd(0, A_TH, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL both_post got=%h exp=%h", got, e); end
  endtask

  task automatic test_unmapped();
    wr(0, A_UN, 32'hDEAD_BEEF);
    wr(0, A_ST, 32'h5555_5555);
    wr(0, A_TH + 32'h1, 32'h0000_0077);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1234_5678);
    rd(0, A_UN, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL unm_read got=%h exp=%h", got, e); end
    rd(0, A_TH, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL unm_th got=%h exp=%h", got, e); end
`ifdef TIMER_SYSTICK_EN
    exp_q.push_back(cyc);
`else
    exp_q.push_back(32'h0);
`endif
    rd(0, A_ST, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL unm_systick got=%h exp=%h", got, e); end
  endtask

  task automatic test_prescaler();
    wr(1, A_TL, 32'h0);
    wr(1, A_TC, 32'h1);
    repeat (8) step();
    exp_q.push_back(32'h2);
    rd(1, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL div4_tl got=%h exp=%h", got, e); end
`ifdef TIMER_SYSTICK_EN
    exp_q.push_back(cyc);
`else
    exp_q.push_back(32'h0);
`endif
    rd(1, A_ST, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL div4_systick got=%h exp=%h", got, e); end
  endtask

  task automatic test_reset_mid();
    wr(0, A_TC, 32'h7);
    n_chk++;
    if (irq[0] !== 1'b1) begin n_err++; $display("FAIL rst_pre_irq got=%b exp=1", irq[0]); end
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if (irq[0] !== 1'b0) begin n_err++; $display("FAIL rst_irq got=%b exp=0", irq[0]); end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    rd(0, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL rst_tl got=%h exp=%h", got, e); end
    rd(1, A_TL, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL rst_tl_div4 got=%h exp=%h", got, e); end
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    exp_q.push_back(32'h0);
    rd(0, A_TC, got); e = exp_q.pop_front(); n_chk++;
    if (got !== e) begin n_err++; $display("FAIL rst_post_tcon got=%h exp=%h", got, e); end
    n_chk++;
    if (irq[0] !== 1'b0) begin n_err++; $display("FAIL rst_post_irq got=%b exp=0", irq[0]); end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; ad[i] = 32'h0; wd[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    test_reset();
    test_overflow_irq();
    test_clear();
    test_irq_disabled();
    test_coincident();
    test_sw_raise();
    test_both_strobe();
    test_unmapped();
    test_prescaler();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
